uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Synthesizable UART transmitter: serializes one 8-bit character per request into a start/data/parity/stop frame on a single line.
- Sits on the TX pin side of the UART path and is the counterpart of the team's receiver model; the bench loops `tx_out` into that model's `rx_in`.
- Frame format, parity convention and baud timing match the receiver model exactly.

Parameters:
- CLK_FREQUENCY, 100_000_000, input clock frequency in Hz.
- BAUD_RATE, 19_200, line bit rate in bits/s.
- PARITY, 1, parity sense: parity bit = XOR(data[7:0]) ^ PARITY (1 = odd, 0 = even).
- Derived: BAUD_CLOCK_CYCLES = CLK_FREQUENCY / BAUD_RATE (integer division; 5208 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- send  in  1  transmit request, level-sensitive.
- din  in  8  character to transmit; sampled only on acceptance.
- busy  out  1  high while a frame is on the line.
- done  out  1  one-cycle pulse when the stop bit completes.
- tx_out  out  1  serial line output, idle high.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous-safe release):
  - state=IDLE, tx_out=1, busy=0, done=0.
  - Baud counter, bit counter and shift register cleared.
  - Reset mid-frame aborts immediately: tx_out returns to 1 with no partial stop bit.
- All outputs are registered; no combinational path from send or din to any output.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - If send=1 at a rising edge: latch din into the shift register, compute parity from the latched value, clear the baud counter, go to START.
  - At that same edge: tx_out<=0, busy<=1.
- START: tx_out=0 for exactly BAUD_CLOCK_CYCLES cycles, then DATA with bit index 0.
- DATA:
  - tx_out=data[i], LSB first, each bit held exactly BAUD_CLOCK_CYCLES cycles.
  - After bit 7, go to PAR.
- PAR: tx_out=parity bit for BAUD_CLOCK_CYCLES cycles, then STOP.
- STOP:
  - tx_out=1 for BAUD_CLOCK_CYCLES cycles.
  - At the final edge: go to IDLE, busy<=0, done<=1 for one cycle.
- Frame length: exactly 11*BAUD_CLOCK_CYCLES cycles from the acceptance edge to the edge where busy falls.
- Baud counter:
  - Counts 0..BAUD_CLOCK_CYCLES-1 and wraps at terminal count.
  - Width is ceil(log2(BAUD_CLOCK_CYCLES)).
  - The bit index is 3 bits and advances only at terminal count.
- Handshake:
  - send is ignored while busy=1.
  - din changes after acceptance do not affect the frame in progress.
  - If send is still high in the IDLE cycle after STOP, a new frame is accepted. This gives a minimum of exactly one idle cycle (tx_out=1) between back-to-back frames, and din is sampled fresh at that point.
- done and a new acceptance cannot coincide: done is asserted on the edge that enters IDLE, and acceptance happens at the earliest on the next edge.
- Elaboration error if BAUD_CLOCK_CYCLES < 2 or PARITY is not 0 or 1.

Test Plan:
- Bench configuration: CLK_FREQUENCY=100_000_000, BAUD_RATE=10_000_000 (BAUD_CLOCK_CYCLES=10) unless stated; tx_out loops into the receiver model with matching parameters.
- Reset with rst=0 for 5 cycles, send=0 -> tx_out=1, busy=0, done=0 throughout; no activity after release.
- din=0x55, PARITY=1, one-cycle send pulse:
  - Line sequence is 0,1,0,1,0,1,0,1,0,1,1 (start, LSB-first data, parity=1, stop), each level held 10 cycles.
  - busy high for exactly 110 cycles; done pulses once.
  - Receiver model prints "RX Received 0x55" with no warnings.
- din=0x01, then 0x00, PARITY=1 -> parity bits are 0 and 1 respectively; PARITY=0 build with din=0x01 -> parity bit 1; receiver reports no parity warning in any case.
- send held high continuously with din=0xA3, then 0x3C, changed mid-frame:
  - First frame carries 0xA3.
  - Exactly one cycle of tx_out=1 separates the frames.
  - Second frame carries the din value present at its acceptance edge (0x3C).
- rst pulled low 37 cycles into a 0xFF frame -> tx_out=1 and busy=0 immediately (asynchronous); after release, send with din=0x12 produces a clean frame received as 0x12.
- Default parameters (BAUD_CLOCK_CYCLES=5208), din=0xC7 -> each bit lasts 5208 cycles (52.08 µs); receiver reports 0xC7.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: one 8-bit character per request, sent as a start/data/parity/stop frame.
// Ports: clk, rst (async active-low), send/din request and character in; busy, done, tx_out registered out.
// Latency: tx_out falls on the acceptance edge. Each of the 11 bits lasts BAUD_CLOCK_CYCLES; send is ignored while busy.
module uart_tx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int PARITY        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       tx_out
);

  localparam int BAUD_CLOCK_CYCLES = CLK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W = (BAUD_CLOCK_CYCLES < 2) ? 1 : $clog2(BAUD_CLOCK_CYCLES);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CLOCK_CYCLES - 1);
  localparam logic PAR_SENSE = 1'(PARITY);

  if (BAUD_CLOCK_CYCLES < 2) begin : g_bad_baud
    $error("uart_tx: BAUD_CLOCK_CYCLES must be at least 2");
  end
  if (PARITY != 0 && PARITY != 1) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0 or 1");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] baud_q, baud_n;
  logic [2:0]       idx_q, idx_n;
  logic [7:0]       shift_q, shift_n;
  logic             par_q, par_n;
  logic             tx_q, tx_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             term;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      idx_q   <= idx_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // The next line level is computed one edge ahead so tx_out stays a plain flop.
  // The shift register always has the next data bit in bit 0.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    idx_n   = idx_q;
    shift_n = shift_q;
    par_n   = par_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    term    = (baud_q == BAUD_LAST);

    if (state_q != IDLE) begin
      baud_n = term ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        baud_n = '0;
        if (send) begin
          shift_n = din;
          par_n   = (^din) ^ PAR_SENSE;
          idx_n   = '0;
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (term) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = shift_q[0];
          shift_n = shift_q >> 1;
        end
      end
      DATA: begin
        if (term) begin
          idx_n = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_n = PAR;
            tx_n    = par_q;
          end else begin
            tx_n    = shift_q[0];
            shift_n = shift_q >> 1;
          end
        end
      end
      PAR: begin
        if (term) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (term) begin
          state_n = IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx. Three instances are used: fast odd parity, fast even parity, and default parameters.
// Expected line levels are built from the frame definition, per bit position.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] send_v = 3'b000;
  logic [7:0] din = 8'h00;
  logic [2:0] busy_v, done_v, tx_v;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQUENCY(100_000_000), .BAUD_RATE(10_000_000), .PARITY(1)) dut0 (
    .clk(clk), .rst(rst), .send(send_v[0]), .din(din),
    .busy(busy_v[0]), .done(done_v[0]), .tx_out(tx_v[0]));

  uart_tx #(.CLK_FREQUENCY(100_000_000), .BAUD_RATE(10_000_000), .PARITY(0)) dut1 (
    .clk(clk), .rst(rst), .send(send_v[1]), .din(din),
    .busy(busy_v[1]), .done(done_v[1]), .tx_out(tx_v[1]));

  uart_tx dut2 (
    .clk(clk), .rst(rst), .send(send_v[2]), .din(din),
    .busy(busy_v[2]), .done(done_v[2]), .tx_out(tx_v[2]));

  task automatic chk(input string tag, input logic obs, input logic expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Line level of bit slot 'pos' in a frame: start, 8 data LSB first, parity, stop.
  function automatic logic frame_level(input logic [7:0] d, input int p, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    if (pos == 9) return (^d) ^ (p != 0);
    return 1'b1;
  endfunction

  task automatic chk_idle(input int k, input string tag);
    chk($sformatf("%s tx d%0d", tag, k), tx_v[k], 1'b1);
    chk($sformatf("%s busy d%0d", tag, k), busy_v[k], 1'b0);
    chk($sformatf("%s done d%0d", tag, k), done_v[k], 1'b0);
  endtask

  // Called just after the acceptance edge; checks ncyc cycles of the frame.
  task automatic check_frame(input int k, input int n, input int p, input logic [7:0] d,
                             input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      chk($sformatf("line d%0d %02h c%0d", k, d, c), tx_v[k], frame_level(d, p, c / n));
      chk($sformatf("busy d%0d c%0d", k, c), busy_v[k], 1'b1);
      chk($sformatf("done d%0d c%0d", k, c), done_v[k], 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_end(input int k);
    chk($sformatf("end tx d%0d", k), tx_v[k], 1'b1);
    chk($sformatf("end busy d%0d", k), busy_v[k], 1'b0);
    chk($sformatf("end done d%0d", k), done_v[k], 1'b1);
  endtask

  task automatic full_frame(input int k, input int n, input int p, input logic [7:0] d);
    din = d;
    send_v[k] = 1'b1;
    @(posedge clk); #1;
    send_v[k] = 1'b0;
    din = ~d;
    check_frame(k, n, p, d, 11 * n);
    chk_end(k);
    @(posedge clk); #1;
    chk_idle(k, "post");
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) chk_idle(k, "reset");
    end
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) chk_idle(k, "release");
    end

    // Directed patterns and parity corners.
    full_frame(0, 10, 1, 8'h55);
    full_frame(0, 10, 1, 8'h01);
    full_frame(0, 10, 1, 8'h00);
    full_frame(1, 10, 0, 8'h01);

    // Random characters on both parity senses.
    repeat (4) full_frame(0, 10, 1, 8'($urandom));
    repeat (4) full_frame(1, 10, 0, 8'($urandom));

    // Send held high: din changes mid-frame, single idle cycle between frames.
    din = 8'hA3;
    send_v[0] = 1'b1;
    @(posedge clk); #1;
    din = 8'h3C;
    check_frame(0, 10, 1, 8'hA3, 110);
    chk_end(0);
    @(posedge clk); #1;
    send_v[0] = 1'b0;
    check_frame(0, 10, 1, 8'h3C, 110);
    chk_end(0);
    @(posedge clk); #1;
    chk_idle(0, "b2b post");

    // Reset 37 cycles into a frame aborts it without waiting for a clock edge.
    din = 8'hFF;
    send_v[0] = 1'b1;
    @(posedge clk); #1;
    send_v[0] = 1'b0;
    check_frame(0, 10, 1, 8'hFF, 37);
    rst = 1'b0;
    #1;
    chk_idle(0, "abort");
    @(posedge clk); #1;
    chk_idle(0, "abort held");
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle(0, "abort release");
    full_frame(0, 10, 1, 8'h12);

    // Default parameters: 5208 cycles per bit.
    full_frame(2, 5208, 1, 8'hC7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
